// File: rtl/invsqrt_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : invsqrt_pkg
//  Description : Shared constants for the inverse-square-root pipeline
//                (float formats, fixed-point format, conversion FSM
//                state encoding used by the float/fixed converters).
//  Revision    : 1.0  initial release
// ============================================================================
package invsqrt_pkg;

    localparam int FLOAT_BIAS    = 127;
    localparam int FXP_FRAC_BITS = 16;
    localparam int FLOAT_EXP_W   = 8;
    localparam int FLOAT_MANT_W  = 23;

    // Conversion-stage FSM encoding
    localparam int        ST_W    = 2;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_NORM = 2'd1;
    localparam logic [1:0] ST_PACK = 2'd2;

endpackage
`default_nettype wire

// File: rtl/fxp_normalizer.sv
`default_nettype none
// ============================================================================
//  Module      : fxp_normalizer
//  Description : Serial normaliser. Holds the working register, shifts it
//                left by one bit per enabled cycle and counts the shifts.
//  Ports       : clk, rst      - clock, async active-high reset
//                i_load        - load i_load_val and clear the count
//                i_load_val    - operand to normalise
//                i_shift       - shift left one bit, increment count
//                o_value       - working register
//                o_count       - number of shifts performed
//                o_zero        - working register is zero
//                o_msb         - bit 31 of the working register
//  Revision    : 1.0  initial release
// ============================================================================
module fxp_normalizer (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_load,
    input  logic [31:0] i_load_val,
    input  logic        i_shift,
    output logic [31:0] o_value,
    output logic [4:0]  o_count,
    output logic        o_zero,
    output logic        o_msb
);

    logic [31:0] r_work;
    logic [4:0]  r_count;

    // Load has priority so a new request always restarts normalisation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_work  <= 32'd0;
            r_count <= 5'd0;
        end else if (i_load) begin
            r_work  <= i_load_val;
            r_count <= 5'd0;
        end else if (i_shift) begin
            r_work  <= {r_work[30:0], 1'b0};
            r_count <= r_count + 5'd1;
        end
    end

    assign o_value = r_work;
    assign o_count = r_count;
    assign o_zero  = (r_work == 32'd0);
    assign o_msb   = r_work[31];

endmodule
`default_nettype wire

// File: rtl/fxp_to_float.sv
`default_nettype none
// ============================================================================
//  Module      : fxp_to_float
//  Description : Unsigned fixed-point (Q16.16 by default) to IEEE-754
//                single-precision converter with serial normalisation
//                (one left shift per clock) and start/ready handshake.
//                Define FXP_TO_FLOAT_ROUND_EN for round-to-nearest-even;
//                otherwise the mantissa is truncated.
//  Ports       : clk, rst   - clock, async active-high reset
//                start      - request, samples fxp_in; aborts any conversion
//                fxp_in     - unsigned fixed-point operand
//                float_out  - single-precision result (held)
//                ready      - float_out valid, cleared by next start
//  Revision    : 1.0  initial release
// ============================================================================
module fxp_to_float
    import invsqrt_pkg::*;
#(
    parameter int FRAC_BITS = FXP_FRAC_BITS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] fxp_in,
    output logic [31:0] float_out,
    output logic        ready
);

    // Exponent of a value whose leading one sits at bit 31.
    localparam logic [FLOAT_EXP_W-1:0] c_EXP_OFFSET =
        FLOAT_EXP_W'(FLOAT_BIAS + 31 - FRAC_BITS);

    logic [ST_W-1:0]         r_state;
    logic [ST_W-1:0]         w_next;
    logic                    w_shift;
    logic                    w_pack;

    logic [31:0]             w_norm;
    logic [4:0]              w_n;
    logic                    w_zero;
    logic                    w_msb;

    logic [FLOAT_EXP_W-1:0]  w_exp_base;
    logic [FLOAT_EXP_W-1:0]  w_exp;
    logic [FLOAT_MANT_W-1:0] w_mant;
    logic [31:0]             w_result;

    logic [31:0]             r_float;
    logic                    r_ready;

    fxp_normalizer u_norm (
        .clk        (clk),
        .rst        (rst),
        .i_load     (start),
        .i_load_val (fxp_in),
        .i_shift    (w_shift),
        .o_value    (w_norm),
        .o_count    (w_n),
        .o_zero     (w_zero),
        .o_msb      (w_msb)
    );

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // FSM: next state. start overrides everything and restarts in NORM.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: w_next = ST_IDLE;
            ST_NORM: if (w_msb || w_zero) w_next = ST_PACK;
            ST_PACK: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
        if (start) begin
            w_next = ST_NORM;
        end
    end

    // FSM: outputs. The zero test stops NORM from shifting forever.
    always_comb begin
        w_shift = 1'b0;
        w_pack  = 1'b0;
        if (!start) begin
            w_shift = (r_state == ST_NORM) && !w_msb && !w_zero;
            w_pack  = (r_state == ST_PACK);
        end
    end

    // ------------------------------------------------------------------
    // Rounding and packing
    // ------------------------------------------------------------------
    assign w_exp_base = c_EXP_OFFSET - {3'b000, w_n};

`ifdef FXP_TO_FLOAT_ROUND_EN
    logic                  w_inc;
    logic [FLOAT_MANT_W:0] w_mant_sum;
    logic                  w_unused;

    // Nearest-even: guard bit 7, sticky bits [6:0], lsb bit 8.
    assign w_inc      = w_norm[7] & ((|w_norm[6:0]) | w_norm[8]);
    assign w_mant_sum = {1'b0, w_norm[30:8]} + {{FLOAT_MANT_W{1'b0}}, w_inc};
    // A carry out leaves the mantissa field at zero and bumps the exponent.
    assign w_mant     = w_mant_sum[FLOAT_MANT_W-1:0];
    assign w_exp      = w_exp_base + {{(FLOAT_EXP_W-1){1'b0}}, w_mant_sum[FLOAT_MANT_W]};
    // Bit 31 is the implicit leading one.
    assign w_unused   = w_norm[31];
`else
    logic w_unused;

    assign w_mant   = w_norm[30:8];
    assign w_exp    = w_exp_base;
    // Implicit leading one and the truncated bits carry no information.
    assign w_unused = ^{w_norm[31], w_norm[7:0]};
`endif

    assign w_result = w_zero ? 32'd0 : {1'b0, w_exp, w_mant};

    // ------------------------------------------------------------------
    // Result register: cleared ready on start, written in PACK.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_float <= 32'd0;
            r_ready <= 1'b0;
        end else if (start) begin
            r_ready <= 1'b0;
        end else if (w_pack) begin
            r_float <= w_result;
            r_ready <= 1'b1;
        end
    end

    assign float_out = r_float;
    assign ready     = r_ready;

endmodule
`default_nettype wire

// File: tb/tb_fxp_to_float.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fxp_to_float
//  Description : Self-checking bench for fxp_to_float. Expected results and
//                latencies are queued when a request is driven and compared
//                when ready rises. Honors FXP_TO_FLOAT_ROUND_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fxp_to_float;
    import invsqrt_pkg::*;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] fxp_in;
    logic [31:0] float_out;
    logic        ready;

    typedef struct {
        logic [31:0] res;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   n_checks;
    int   n_pass;

    fxp_to_float #(.FRAC_BITS(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .fxp_in    (fxp_in),
        .float_out (float_out),
        .ready     (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs === expv) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, obs, expv);
        end
    endtask

    // Reference conversion: locate the leading one, normalise in one step.
    function automatic logic [31:0] model(input logic [31:0] x);
        int          p;
        logic [31:0] m;
        logic [23:0] sum;
        logic [7:0]  e;
        if (x == 32'd0) return 32'd0;
        p = 31;
        while (x[p] == 1'b0) p--;
        m   = x << (31 - p);
        e   = 8'(FLOAT_BIAS + p - 16);
        sum = {1'b0, m[30:8]};
`ifdef FXP_TO_FLOAT_ROUND_EN
        if (m[7] && ((m[6:0] != 7'd0) || m[8])) sum = sum + 24'd1;
        if (sum[23]) e = e + 8'd1;
`endif
        return {1'b0, e, sum[22:0]};
    endfunction

    function automatic int model_lat(input logic [31:0] x);
        int z;
        z = 0;
        if (x == 32'd0) return 2;
        for (int i = 31; i >= 0; i--) begin
            if (x[i]) break;
            z++;
        end
        return z + 2;
    endfunction

    // Issue one request, then wait (bounded) for ready and score it.
    task automatic run(input string tag, input logic [31:0] x,
                       input logic [31:0] expv, input int explat);
        exp_t e;
        exp_t got;
        int   lat;
        e.res = expv;
        e.lat = explat;
        @(negedge clk);
        fxp_in = x;
        start  = 1'b1;
        sb.push_back(e);
        @(posedge clk);
        #1;
        start = 1'b0;
        check({tag, "_ready_drop"}, {31'd0, ready}, 32'd0);
        lat = 0;
        while (!ready && lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
        end
        got = sb.pop_front();
        if (!ready) begin
            check({tag, "_timeout"}, {31'd0, ready}, 32'd1);
        end else begin
            check({tag, "_value"}, float_out, got.res);
            check({tag, "_latency"}, lat, got.lat);
        end
    endtask

    initial begin
        logic [31:0] rx;
        n_checks = 0;
        n_pass   = 0;
        rst      = 1'b1;
        start    = 1'b0;
        fxp_in   = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ready", {31'd0, ready}, 32'd0);
        check("reset_float", float_out, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run("one",  32'h0001_0000, 32'h3F80_0000, 17);
        run("half", 32'h0000_8000, 32'h3F00_0000, 18);
        run("zero", 32'h0000_0000, 32'h0000_0000, 2);
        run("tiny", 32'h0000_0001, 32'h3780_0000, 33);
`ifdef FXP_TO_FLOAT_ROUND_EN
        run("max",      32'hFFFF_FFFF, 32'h4780_0000, 2);
        run("tie_even", 32'h8000_0080, 32'h4700_0000, 2);
        run("tie_odd",  32'h8000_0180, 32'h4700_0002, 2);
`else
        run("max",      32'hFFFF_FFFF, 32'h477F_FFFF, 2);
        run("tie_even", 32'h8000_0080, 32'h4700_0000, 2);
        run("tie_odd",  32'h8000_0180, 32'h4700_0001, 2);
`endif

        for (int i = 0; i < 8; i++) begin
            rx = $urandom >> $urandom_range(0, 31);
            run("rand", rx, model(rx), model_lat(rx));
        end

        // Abort: restart 5 cycles into a long conversion.
        @(negedge clk);
        fxp_in = 32'h0000_0001;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("abort_mid_ready", {31'd0, ready}, 32'd0);
        run("abort_restart", 32'h0001_0000, 32'h3F80_0000, 17);
        @(posedge clk);
        #1;
        check("abort_hold_ready", {31'd0, ready}, 32'd1);
        check("abort_hold_float", float_out, 32'h3F80_0000);
        repeat (20) @(posedge clk);
        #1;
        check("abort_single_float", float_out, 32'h3F80_0000);

        // Reset mid-conversion discards the result and idles the FSM.
        @(negedge clk);
        fxp_in = 32'h0000_0001;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_ready", {31'd0, ready}, 32'd0);
        check("rst_float", float_out, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        check("rst_idle_ready", {31'd0, ready}, 32'd0);
        check("rst_idle_float", float_out, 32'd0);
        run("after_rst", 32'h0000_8000, 32'h3F00_0000, 18);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
